// File: rtl/sc_score_keeper_pkg.sv
// -----------------------------------------------------------------------------
// sc_score_pkg
// Shared definitions for the score keeper: grade encodings, timing-window
// thresholds, base point values, combo multiplier breakpoints and the small
// grading helpers used by the top level.
// -----------------------------------------------------------------------------
package sc_score_pkg;

   localparam int IDX_W   = 6;   // note index width (covers up to 64 lanes)
   localparam int DELTA_W = 8;   // saturated timing error width
   localparam int COMBO_W = 10;
   localparam int DROP_W  = 8;
   localparam int PTS_W   = 7;   // base points (max 100)
   localparam int SPTS_W  = 9;   // scaled points (max 400)

   typedef enum logic [1:0] {
      GRADE_MISS    = 2'd0,
      GRADE_OK      = 2'd1,
      GRADE_GOOD    = 2'd2,
      GRADE_PERFECT = 2'd3
   } grade_t;

   localparam logic [DELTA_W-1:0] THR_PERFECT = 8'd2;
   localparam logic [DELTA_W-1:0] THR_GOOD    = 8'd5;
   localparam logic [DELTA_W-1:0] THR_OK      = 8'd10;

   localparam logic [PTS_W-1:0] PTS_PERFECT = 7'd100;
   localparam logic [PTS_W-1:0] PTS_GOOD    = 7'd50;
   localparam logic [PTS_W-1:0] PTS_OK      = 7'd20;

   localparam logic [COMBO_W-1:0] COMBO_X2  = 10'd10;
   localparam logic [COMBO_W-1:0] COMBO_X3  = 10'd20;
   localparam logic [COMBO_W-1:0] COMBO_X4  = 10'd30;
   localparam logic [COMBO_W-1:0] COMBO_MAX = 10'd1023;

   function automatic grade_t grade_of(input logic [DELTA_W-1:0] delta);
      if (delta <= THR_PERFECT)   return GRADE_PERFECT;
      else if (delta <= THR_GOOD) return GRADE_GOOD;
      else if (delta <= THR_OK)   return GRADE_OK;
      else                        return GRADE_MISS;
   endfunction

   function automatic logic [PTS_W-1:0] base_pts(input grade_t g);
      case (g)
         GRADE_PERFECT: return PTS_PERFECT;
         GRADE_GOOD:    return PTS_GOOD;
         GRADE_OK:      return PTS_OK;
         default:       return '0;
      endcase
   endfunction

endpackage

// File: rtl/sc_score_keeper_if.sv
// -----------------------------------------------------------------------------
// sc_score_keeper_if
// Bundle between the note-matching stage (master) and the score keeper
// (slave).
//   song_time     : current song time
//   match_trigger : one-cycle pulse per matched note lane
//   match_time    : scheduled time of lane i at [TW*i +: TW]
//   grade_valid   : one-cycle pulse per produced grade
//   grade         : MISS/OK/GOOD/PERFECT
//   grade_note    : lane index of the graded note
//   combo         : current consecutive non-MISS count
//   max_combo     : highest combo since reset/clear
//   score         : accumulated score
//   drop_count    : triggers overwritten while still pending
// -----------------------------------------------------------------------------
interface sc_score_keeper_if
   import sc_score_pkg::*;
#(
   parameter int NUM_NOTES = 37,
   parameter int TW        = 16,
   parameter int SCORE_W   = 24
);
   logic [TW-1:0]           song_time;
   logic [NUM_NOTES-1:0]    match_trigger;
   logic [NUM_NOTES*TW-1:0] match_time;
   logic                    grade_valid;
   grade_t                  grade;
   logic [IDX_W-1:0]        grade_note;
   logic [COMBO_W-1:0]      combo;
   logic [COMBO_W-1:0]      max_combo;
   logic [SCORE_W-1:0]      score;
   logic [DROP_W-1:0]       drop_count;

   modport master (
      output song_time, match_trigger, match_time,
      input  grade_valid, grade, grade_note, combo, max_combo, score, drop_count
   );

   modport slave (
      input  song_time, match_trigger, match_time,
      output grade_valid, grade, grade_note, combo, max_combo, score, drop_count
   );
endinterface

// File: rtl/sc_score_keeper_note_arbiter.sv
// -----------------------------------------------------------------------------
// sc_note_arbiter
// Combinational find-first-set over the pending lanes; lowest index wins.
//   req : pending lane bits
//   idx : index of the lowest set bit (0 when none)
//   any : at least one bit set
// -----------------------------------------------------------------------------
module sc_note_arbiter
   import sc_score_pkg::*;
#(
   parameter int NUM_NOTES = 37
) (
   input  logic [NUM_NOTES-1:0] req,
   output logic [IDX_W-1:0]     idx,
   output logic                 any
);

   // Scanning downward lets the lowest set index overwrite higher ones.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = NUM_NOTES - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = IDX_W'(i);
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sc_score_keeper.sv
// -----------------------------------------------------------------------------
// sc_score_keeper
// Grades note hits against song time and keeps combo / score state.
// Triggers are captured into per-lane pending bits with a saturated timing
// error; one pending lane (lowest index first) is graded per clock.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   clear : synchronous song restart, identical effect to rst
//   sk    : slave side of sc_score_keeper_if (inputs from the matcher,
//           grade/combo/score outputs for display)
// -----------------------------------------------------------------------------
module sc_score_keeper
   import sc_score_pkg::*;
#(
   parameter int NUM_NOTES = 37,
   parameter int TW        = 16,
   parameter int SCORE_W   = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   sc_score_keeper_if.slave   sk
);

   function automatic logic [DELTA_W-1:0] abs_sat_delta(
      input logic [TW-1:0] t_now,
      input logic [TW-1:0] t_sched
   );
      logic signed [TW:0] diff;
      logic        [TW:0] mag;
      diff = signed'({1'b0, t_now}) - signed'({1'b0, t_sched});
      mag  = diff[TW] ? unsigned'(-diff) : unsigned'(diff);
      return (mag > (TW+1)'(255)) ? {DELTA_W{1'b1}} : mag[DELTA_W-1:0];
   endfunction

   function automatic logic [COMBO_W-1:0] sat_inc_combo(input logic [COMBO_W-1:0] c);
      return (c == COMBO_MAX) ? c : c + 1'b1;
   endfunction

   // x3 built from shift+add to keep the datapath multiplier-free.
   function automatic logic [SPTS_W-1:0] scale_pts(
      input logic [PTS_W-1:0]   base,
      input logic [COMBO_W-1:0] c
   );
      logic [SPTS_W-1:0] b;
      b = {{(SPTS_W-PTS_W){1'b0}}, base};
      if (c >= COMBO_X4)      return b << 2;
      else if (c >= COMBO_X3) return (b << 1) + b;
      else if (c >= COMBO_X2) return b << 1;
      else                    return b;
   endfunction

   function automatic logic [SCORE_W-1:0] sat_add_score(
      input logic [SCORE_W-1:0] s,
      input logic [SPTS_W-1:0]  p
   );
      logic [SCORE_W:0] sum;
      sum = {1'b0, s} + (SCORE_W+1)'(p);
      return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
   endfunction

   function automatic logic [DROP_W-1:0] sat_add_drop(
      input logic [DROP_W-1:0] d,
      input logic [6:0]        n
   );
      logic [DROP_W:0] sum;
      sum = {1'b0, d} + (DROP_W+1)'(n);
      return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
   endfunction

   logic [NUM_NOTES-1:0] pending_p0;
   logic [DELTA_W-1:0]   delta_p0 [NUM_NOTES];
   logic [DELTA_W-1:0]   delta_new [NUM_NOTES];

   logic                 vld_p1;
   grade_t               grade_p1;
   logic [IDX_W-1:0]     note_p1;
   logic [COMBO_W-1:0]   combo_p1;
   logic [COMBO_W-1:0]   max_combo_p1;
   logic [SCORE_W-1:0]   score_p1;
   logic [DROP_W-1:0]    drop_p1;

   logic [IDX_W-1:0]     sel_idx;
   logic                 sel_any;
   logic [NUM_NOTES-1:0] serviced_mask;
   logic [DELTA_W-1:0]   sel_delta;
   grade_t               sel_grade;
   logic [COMBO_W-1:0]   combo_nxt;
   logic [SPTS_W-1:0]    pts_nxt;
   logic [NUM_NOTES-1:0] drop_vec;
   logic [6:0]           drop_inc;

   always_comb begin
      for (int i = 0; i < NUM_NOTES; i++) begin
         delta_new[i] = abs_sat_delta(sk.song_time, sk.match_time[i*TW +: TW]);
      end
   end

   sc_note_arbiter #(
      .NUM_NOTES (NUM_NOTES)
   ) u_arb (
      .req (pending_p0),
      .idx (sel_idx),
      .any (sel_any)
   );

   // ---- stage p0 -> p1: grade the arbitrated lane ----
   always_comb begin
      serviced_mask = sel_any ? (NUM_NOTES'(1) << sel_idx) : '0;
      sel_delta     = delta_p0[sel_idx];
      sel_grade     = grade_of(sel_delta);
      combo_nxt     = (sel_grade == GRADE_MISS) ? '0 : sat_inc_combo(combo_p1);
      pts_nxt       = scale_pts(base_pts(sel_grade), combo_nxt);
      // A retrigger on the lane being graded is not a drop: the old delta
      // is consumed this cycle and the new one re-arms the lane.
      drop_vec      = sk.match_trigger & pending_p0 & ~serviced_mask;
      drop_inc      = '0;
      for (int i = 0; i < NUM_NOTES; i++) begin
         drop_inc = drop_inc + 7'(drop_vec[i]);
      end
   end

   // ---- stage p0: capture triggers / stage p1: registered outputs ----
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         pending_p0   <= '0;
         for (int i = 0; i < NUM_NOTES; i++) begin
            delta_p0[i] <= '0;
         end
         vld_p1       <= 1'b0;
         grade_p1     <= GRADE_MISS;
         note_p1      <= '0;
         combo_p1     <= '0;
         max_combo_p1 <= '0;
         score_p1     <= '0;
         drop_p1      <= '0;
      end else begin
         pending_p0 <= (pending_p0 & ~serviced_mask) | sk.match_trigger;
         for (int i = 0; i < NUM_NOTES; i++) begin
            if (sk.match_trigger[i]) begin
               delta_p0[i] <= delta_new[i];
            end
         end
         vld_p1  <= sel_any;
         drop_p1 <= sat_add_drop(drop_p1, drop_inc);
         if (sel_any) begin
            grade_p1     <= sel_grade;
            note_p1      <= sel_idx;
            combo_p1     <= combo_nxt;
            max_combo_p1 <= (combo_nxt > max_combo_p1) ? combo_nxt : max_combo_p1;
            score_p1     <= sat_add_score(score_p1, pts_nxt);
         end
      end
   end

   assign sk.grade_valid = vld_p1;
   assign sk.grade       = grade_p1;
   assign sk.grade_note  = note_p1;
   assign sk.combo       = combo_p1;
   assign sk.max_combo   = max_combo_p1;
   assign sk.score       = score_p1;
   assign sk.drop_count  = drop_p1;

endmodule

// File: tb/tb_sc_score_keeper.sv
// -----------------------------------------------------------------------------
// tb_sc_score_keeper
// Scoreboard bench for sc_score_keeper: expected grades are queued as hits
// are driven and compared when grade_valid pulses.
// -----------------------------------------------------------------------------
module tb_sc_score_keeper;
   import sc_score_pkg::*;

   localparam int NUM_NOTES = 37;
   localparam int TW        = 16;
   localparam int SCORE_W   = 24;

   logic clk = 1'b0;
   logic rst;
   logic clear;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sc_score_keeper_if #(.NUM_NOTES(NUM_NOTES), .TW(TW), .SCORE_W(SCORE_W)) sk();

   sc_score_keeper #(.NUM_NOTES(NUM_NOTES), .TW(TW), .SCORE_W(SCORE_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .sk    (sk)
   );

   typedef struct {
      int g;
      int note;
      int combo;
      int maxc;
      int score;
      int drop;
      int ecyc;
   } exp_t;

   exp_t q[$];

   int m_combo = 0;
   int m_max   = 0;
   int m_score = 0;
   int m_drop  = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int model_delta(input int st, input int mt);
      int d;
      d = st - mt;
      if (d < 0) d = -d;
      if (d > 255) d = 255;
      return d;
   endfunction

   task automatic model_hit(input int note, input int delta, input int ecyc);
      int g, base, mult;
      exp_t e;
      if (delta <= 2)       begin g = 3; base = 100; end
      else if (delta <= 5)  begin g = 2; base = 50;  end
      else if (delta <= 10) begin g = 1; base = 20;  end
      else                  begin g = 0; base = 0;   end
      if (g == 0) m_combo = 0;
      else if (m_combo < 1023) m_combo++;
      if (m_combo > m_max) m_max = m_combo;
      if (m_combo >= 30)      mult = 4;
      else if (m_combo >= 20) mult = 3;
      else if (m_combo >= 10) mult = 2;
      else                    mult = 1;
      m_score = m_score + base * mult;
      if (m_score > (1 << SCORE_W) - 1) m_score = (1 << SCORE_W) - 1;
      e.g = g; e.note = note; e.combo = m_combo; e.maxc = m_max;
      e.score = m_score; e.drop = m_drop; e.ecyc = ecyc;
      q.push_back(e);
   endtask

   task automatic model_reset();
      m_combo = 0; m_max = 0; m_score = 0; m_drop = 0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sk.grade_valid) begin
         if (q.size() == 0) begin
            chk("spurious_grade_valid", 1, 0);
         end else begin
            e = q.pop_front();
            chk("grade",      int'(sk.grade),     e.g);
            chk("grade_note", int'(sk.grade_note), e.note);
            chk("combo",      int'(sk.combo),     e.combo);
            chk("max_combo",  int'(sk.max_combo), e.maxc);
            chk("score",      int'(sk.score),     e.score);
            chk("drop_count", int'(sk.drop_count), e.drop);
            if (e.ecyc >= 0) chk("latency", cyc, e.ecyc);
         end
      end
   end

   task automatic set_mt(input int n, input int t);
      logic [31:0] tv;
      tv = t;
      sk.match_time[n*TW +: TW] = tv[TW-1:0];
   endtask

   task automatic hit(input int note, input int st, input int mt);
      logic [31:0] sv;
      @(negedge clk);
      sv = st;
      sk.song_time = sv[TW-1:0];
      set_mt(note, mt);
      sk.match_trigger = '0;
      sk.match_trigger[note] = 1'b1;
      model_hit(note, model_delta(st, mt), cyc + 2);
      @(negedge clk);
      sk.match_trigger = '0;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
      chk("drain_timeout", q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grade_valid"}, int'(sk.grade_valid), 0);
      chk({tag, "_grade"},       int'(sk.grade),       0);
      chk({tag, "_grade_note"},  int'(sk.grade_note),  0);
      chk({tag, "_combo"},       int'(sk.combo),       0);
      chk({tag, "_max_combo"},   int'(sk.max_combo),   0);
      chk({tag, "_score"},       int'(sk.score),       0);
      chk({tag, "_drop_count"},  int'(sk.drop_count),  0);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_reset();
   endtask

   initial begin
      int base_cyc;
      rst = 1'b1;
      clear = 1'b0;
      sk.song_time = '0;
      sk.match_trigger = '0;
      sk.match_time = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_all_zero("reset");

      // First PERFECT hit, uncontended latency
      hit(0, 15, 15);
      drain();

      // MISS then GOOD
      hit(3, 40, 20);
      hit(1, 40, 36);
      drain();

      // Idle hold: outputs keep last values
      chk("idle_grade_valid", int'(sk.grade_valid), 0);
      chk("idle_score_hold",  int'(sk.score), m_score);
      chk("idle_note_hold",   int'(sk.grade_note), 1);

      // Three-lane burst, serviced lowest index first
      @(negedge clk);
      base_cyc = cyc;
      sk.song_time = 16'd100;
      set_mt(0, 100); set_mt(4, 100); set_mt(36, 100);
      sk.match_trigger = '0;
      sk.match_trigger[0] = 1'b1;
      sk.match_trigger[4] = 1'b1;
      sk.match_trigger[36] = 1'b1;
      model_hit(0, 0, base_cyc + 2);
      model_hit(4, 0, base_cyc + 3);
      model_hit(36, 0, base_cyc + 4);
      @(negedge clk);
      sk.match_trigger = '0;
      drain();

      // Threshold boundaries, both signs of error, and wrap-free saturation
      hit(2, 10, 12);      // 2  -> PERFECT
      hit(2, 13, 10);      // 3  -> GOOD
      hit(6, 20, 25);      // 5  -> GOOD
      hit(6, 26, 20);      // 6  -> OK
      hit(9, 30, 40);      // 10 -> OK
      hit(9, 41, 30);      // 11 -> MISS
      hit(8, 0, 65535);    // 65535 saturates -> MISS
      hit(8, 500, 100);    // 400 saturates -> MISS
      drain();

      // Combo multiplier ramp from a clean start, then a MISS
      do_clear();
      for (int i = 0; i < 20; i++) hit(7, 1000, 1000);
      hit(7, 1000, 900);
      drain();
      for (int i = 0; i < 12; i++) hit(11, 300, 301);
      drain();

      // Retrigger of a pending, not-yet-serviced lane
      do_clear();
      @(negedge clk);
      base_cyc = cyc;
      sk.song_time = 16'd200;
      for (int k = 0; k <= 5; k++) set_mt(k, 200);
      sk.match_trigger = '0;
      for (int k = 0; k <= 5; k++) sk.match_trigger[k] = 1'b1;
      m_drop = 1;
      for (int k = 0; k <= 4; k++) model_hit(k, 0, base_cyc + 2 + k);
      model_hit(5, 8, base_cyc + 7);
      @(negedge clk);
      sk.match_trigger = '0;
      sk.match_trigger[5] = 1'b1;
      set_mt(5, 208);
      @(negedge clk);
      sk.match_trigger = '0;
      drain();

      // clear one cycle after a burst discards all pending work
      @(negedge clk);
      sk.match_trigger = '0;
      sk.match_trigger[0] = 1'b1;
      sk.match_trigger[1] = 1'b1;
      sk.match_trigger[2] = 1'b1;
      @(negedge clk);
      sk.match_trigger = '0;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_reset();
      chk_all_zero("clear");
      repeat (6) @(negedge clk);
      chk("post_clear_queue", q.size(), 0);
      chk_all_zero("post_clear");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
